chebyshev_output_stage: RTL

Output-side (source-end) block for the Chebyshev evaluator. It accepts full-width Horner results from the computation datapath over a valid/ready handshake. Each result is rounded half-up and saturated to O_BITS, then buffered in a small FIFO. The FIFO drives the downstream source_valid/source_ready interface, so backpressure from the consumer propagates to the evaluator through result_ready.

---
 rtl/chebyshev_output_stage.sv | 96 +++++++++
 1 files changed

// File: rtl/chebyshev_output_stage.sv
// Source-end stage of the Chebyshev evaluator: rounds each Horner result half-up,
// saturates it to O_BITS and queues it in a small FIFO in front of the consumer.
module chebyshev_output_stage #(
  parameter int IN_W     = 40,
  parameter int DROP     = 16,
  parameter int O_BITS   = 16,
  parameter int DEPTH    = 4,
  parameter int PTR_BITS = 2
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [IN_W-1:0]     result_in,
  input  logic                result_valid,
  output logic                result_ready,
  output logic [O_BITS-1:0]   source_data,
  output logic                source_valid,
  input  logic                source_ready,
  output logic                sat_flag,
  input  logic                sat_clear,
  output logic [PTR_BITS:0]   level
);

  localparam int QW = IN_W + 1 - DROP;
  localparam int EW = (QW > O_BITS) ? QW : O_BITS + 1;
  localparam logic [IN_W:0]       HALF       = (IN_W+1)'(1) << (DROP - 1);
  localparam logic [PTR_BITS:0]   FULL_LEVEL = (PTR_BITS+1)'(DEPTH);
  localparam logic [O_BITS-1:0]   MAX_OUT    = {1'b0, {(O_BITS-1){1'b1}}};
  localparam logic [O_BITS-1:0]   MIN_OUT    = {1'b1, {(O_BITS-1){1'b0}}};

  logic [IN_W:0]          sum;
  logic signed [QW-1:0]   q;
  logic signed [EW-1:0]   q_ext;
  logic                   sat_hi;
  logic                   sat_lo;
  logic [O_BITS-1:0]      rounded;

  logic [O_BITS-1:0]      mem [DEPTH];
  logic [PTR_BITS-1:0]    wr_ptr;
  logic [PTR_BITS-1:0]    rd_ptr;
  logic [O_BITS-1:0]      last_data;
  logic                   push;
  logic                   pop;

  // Taking the top bits of the sign-extended sum is the arithmetic shift by DROP;
  // the sum cannot overflow because only a small positive constant is added.
  assign sum     = {result_in[IN_W-1], result_in} + HALF;
  assign q       = $signed(sum[IN_W:DROP]);
  assign q_ext   = EW'(q);
  assign sat_hi  = ~q_ext[EW-1] & (|q_ext[EW-2:O_BITS-1]);
  assign sat_lo  =  q_ext[EW-1] & ~(&q_ext[EW-2:O_BITS-1]);
  assign rounded = sat_hi ? MAX_OUT : (sat_lo ? MIN_OUT : q_ext[O_BITS-1:0]);

  assign result_ready = (level != FULL_LEVEL);
  assign source_valid = (level != '0);
  assign push         = result_valid & result_ready;
  assign pop          = source_valid & source_ready;

  // When empty the output shows the last popped word rather than a stale slot.
  assign source_data  = source_valid ? mem[rd_ptr] : last_data;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= rounded;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      last_data <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_BITS'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_BITS'(1);
        last_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level <= level + (PTR_BITS+1)'(1);
        2'b01:   level <= level - (PTR_BITS+1)'(1);
        default: level <= level;
      endcase
      // A saturating push outranks a clear arriving on the same edge.
      if (push && (sat_hi || sat_lo)) begin
        sat_flag <= 1'b1;
      end else if (sat_clear) begin
        sat_flag <= 1'b0;
      end
    end
  end

endmodule
